instr_fetch_unit: RTL and testbench

Front-end stage directly upstream of the execute unit. It owns the program counter and fetches 32-bit instruction words from instruction memory over a valid/ready request channel and an in-order response channel. Fetched words are buffered and presented to execute as the instruction register value, with a valid/ready handshake. It also handles PC redirects (jumps) and a HALT opcode.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, instruction memory fetch and instruction buffer feeding execute.
// Define IFU_PREFETCH_EN for a two-entry buffer that overlaps the next request with the current response.
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               halted
);
`ifdef IFU_PREFETCH_EN
    localparam logic [1:0] BUF_DEPTH = 2'd2;
`else
    localparam logic [1:0] BUF_DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t state, state_n;
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] fifo_data [2];
    logic [ADDR_W-1:0] fifo_pc [2];
    logic [1:0] count, cnt_next;
    logic discard, pop, push, halt_word, can_req, stale_after;

    assign ir_valid = count != 2'd0;
    assign ir_data = fifo_data[0];
    assign ir_pc = fifo_pc[0];
    assign pop = ir_valid && ir_ready;
    assign push = state == WAIT && imem_rsp_valid;
    assign halt_word = imem_rsp_data[INSTR_W-1 -: 5] == HALT_OP;
    assign cnt_next = count + {1'b0, push} - {1'b0, pop};
    // A stale response still in flight blocks new requests so only one is ever outstanding.
    assign can_req = run && !redir_valid && cnt_next < BUF_DEPTH && !(discard && !imem_rsp_valid);
    // A response that will still arrive after this edge must be thrown away.
    assign stale_after = ((state == WAIT || discard) && !imem_rsp_valid) || (imem_req_valid && imem_req_ready);

    // Next-state and request channel; in WAIT the next request overlaps the arriving response.
    always_comb begin
        state_n = state;
        imem_req_valid = 1'b0;
        imem_req_addr = pc;
        case (state)
            IDLE: state_n = can_req ? REQ : IDLE;
            REQ: begin
                imem_req_valid = 1'b1;
                state_n = imem_req_ready ? WAIT : REQ;
            end
            WAIT: if (imem_rsp_valid) begin
                imem_req_valid = can_req && !halt_word;
                state_n = halt_word ? HALT : !can_req ? IDLE : imem_req_ready ? WAIT : REQ;
            end
            default: state_n = state;
        endcase
        if (redir_valid) state_n = (state == REQ && !imem_req_ready) ? REQ : IDLE;
    end

    // State, program counter, stale-response flag and halted status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            discard <= stale_after;
            halted <= 1'b0;
        end else begin
            state <= state_n;
            pc <= redir_valid ? redir_pc : (imem_req_valid && imem_req_ready) ? pc + ADDR_W'(1) : pc;
            discard <= redir_valid ? stale_after : discard && !imem_rsp_valid;
            halted <= redir_valid ? 1'b0 : halted || (pop && ir_data[INSTR_W-1 -: 5] == HALT_OP);
        end
    end

    // Shift-register instruction buffer; head is always entry 0, the PC of a push is the last accepted address.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            fifo_data <= '{default: '0};
            fifo_pc <= '{default: '0};
        end else if (redir_valid) begin
            count <= 2'd0;
        end else begin
            count <= cnt_next;
            if (pop) begin
                fifo_data[0] <= fifo_data[1];
                fifo_pc[0] <= fifo_pc[1];
            end
            if (push) begin
                fifo_data[count[0] ^ pop] <= imem_rsp_data;
                fifo_pc[count[0] ^ pop] <= pc - ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench with a behavioural instruction memory of selectable latency.
module tb_instr_fetch_unit;
`ifdef IFU_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr;
    logic imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic redir_valid = 1'b0;
    logic [15:0] redir_pc = '0;
    logic ir_valid;
    logic ir_ready = 1'b0;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;
    logic halted;

    int tests = 0;
    int fails = 0;
    int lat = 1;
    logic halt_en = 1'b0;
    logic [3:0] pv = '0;
    logic [15:0] pa [4] = '{default: '0};
    logic [15:0] rsp_addr;
    int cnt20 = 0;
    int hi_reqs = 0;
    logic wrap_seen = 1'b0;
    logic [15:0] prev_addr = '0;
    logic hs;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .halted(halted)
    );

    always #5 clk = ~clk;

    assign hs = (imem_req_valid === 1'b1) && imem_req_ready;
    assign imem_rsp_valid = pv[lat-1];
    assign rsp_addr = pa[lat-1];
    assign imem_rsp_data = (halt_en && rsp_addr == 16'd5) ? 32'hF800_0000 : {16'h0800, rsp_addr};

    // Memory: response arrives lat edges after the accepting edge; request log for address checks.
    always @(posedge clk) begin
        pv <= {pv[2:0], hs};
        pa[0] <= imem_req_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pa[3] <= pa[2];
        if (hs) begin
            if (imem_req_addr >= 16'h20 && imem_req_addr < 16'h40) cnt20 <= cnt20 + 1;
            if (halt_en && imem_req_addr >= 16'd6 && imem_req_addr < 16'd16) hi_reqs <= hi_reqs + 1;
            if (imem_req_addr == 16'h0000 && prev_addr == 16'hFFFF) wrap_seen <= 1'b1;
            prev_addr <= imem_req_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic get_ir(output logic [15:0] p, output logic [31:0] d);
        int k = 0;
        @(negedge clk);
        while (!ir_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ir_timeout", 32'(ir_valid), 32'd1);
        p = ir_pc;
        d = ir_data;
    endtask

    task automatic expect_ir(input string tag, input logic [15:0] exp);
        logic [15:0] p;
        logic [31:0] d;
        get_ir(p, d);
        check({tag, "_pc"}, 32'(p), 32'(exp));
        check({tag, "_data"}, d, {16'h0800, exp});
    endtask

    task automatic redirect(input logic [15:0] a);
        redir_pc = a;
        redir_valid = 1'b1;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    initial begin
        int k;
        int lats [2] = '{2, 4};
        logic [15:0] p;
        logic [31:0] d;
        imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_ir_valid", 32'(ir_valid), 32'd0);
        check("rst_ir_data", ir_data, 32'd0);
        check("rst_ir_pc", 32'(ir_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        rst = 1'b0;
        run = 1'b1;
        ir_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ir_valid && k < 10);
        check("first_latency", 32'(k), 32'd3);
        check("seq0_pc", 32'(ir_pc), 32'd0);
        check("seq0_data", ir_data, 32'h0800_0000);
        expect_ir("seq1", 16'd1);
        expect_ir("seq2", 16'd2);
        expect_ir("seq3", 16'd3);

        k = 0;
        while (!imem_req_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", 32'(imem_req_valid), 32'd1);
        ir_ready = 1'b0;
        redirect(16'h20);
        repeat (4) @(negedge clk);
        check("stall_pc_early", 32'(ir_pc), 32'h20);
        repeat (8) @(negedge clk);
        check("stall_valid", 32'(ir_valid), 32'd1);
        check("stall_pc", 32'(ir_pc), 32'h20);
        check("stall_data", ir_data, 32'h0800_0020);
        check("stall_req_count", 32'(cnt20), 32'(DEPTH));
        check("stall_req_idle", 32'(imem_req_valid), 32'd0);
        ir_ready = 1'b1;
        expect_ir("drain1", 16'h21);
        expect_ir("drain2", 16'h22);

        k = 0;
        while (!imem_rsp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("rsp_seen", 32'(imem_rsp_valid), 32'd1);
        ir_ready = 1'b0;
        redirect(16'h40);
        ir_ready = 1'b1;
        expect_ir("redir0", 16'h40);
        expect_ir("redir1", 16'h41);
        expect_ir("redir2", 16'h42);

        ir_ready = 1'b0;
        redirect(16'hFFFF);
        ir_ready = 1'b1;
        expect_ir("wrap_a", 16'hFFFF);
        expect_ir("wrap_b", 16'h0000);
        check("wrap_req_seq", 32'(wrap_seen), 32'd1);

        ir_ready = 1'b0;
        repeat (6) @(negedge clk);
        halt_en = 1'b1;
        redirect(16'd3);
        ir_ready = 1'b1;
        expect_ir("halt3", 16'd3);
        expect_ir("halt4", 16'd4);
        get_ir(p, d);
        check("halt5_pc", 32'(p), 32'd5);
        check("halt5_data", d, 32'hF800_0000);
        check("halted_before_pop", 32'(halted), 32'd0);
        @(negedge clk);
        check("halted_after_pop", 32'(halted), 32'd1);
        repeat (8) @(negedge clk);
        check("halted_held", 32'(halted), 32'd1);
        check("halt_no_reqs", 32'(hi_reqs), 32'd0);
        check("halt_req_idle", 32'(imem_req_valid), 32'd0);
        check("halt_ir_empty", 32'(ir_valid), 32'd0);
        redirect(16'h10);
        check("halted_cleared", 32'(halted), 32'd0);
        expect_ir("resume", 16'h10);

        foreach (lats[i]) begin
            ir_ready = 1'b0;
            repeat (8) @(negedge clk);
            lat = lats[i];
            redirect(16'h30);
            k = 0;
            while (!imem_req_valid && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("rst_req_seen", 32'(imem_req_valid), 32'd1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("wait_rst_ir_valid", 32'(ir_valid), 32'd0);
            check("wait_rst_ir_pc", 32'(ir_pc), 32'd0);
            check("wait_rst_halted", 32'(halted), 32'd0);
            repeat (2) begin
                @(negedge clk);
                check("wait_rst_still_empty", 32'(ir_valid), 32'd0);
            end
            ir_ready = 1'b1;
            expect_ir("wait_rst_restart", 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
